// File: rtl/serial_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// serial_frame_rx_pkg
// Shared types and line-level constants for the serial frame receiver.
//   state_t    : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   START_BIT  : level that opens a frame when the line is idle
//   STOP_BIT   : level a well-formed frame ends with
//   IDLE_LEVEL : level the line rests at between frames
// ---------------------------------------------------------------------------
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage : serial_frame_rx_pkg

// File: rtl/serial_frame_rx_if.sv
// ---------------------------------------------------------------------------
// serial_frame_rx_if
// Parallel valid/ready output bundle of the serial frame receiver.
//   out_ready  : consumer accepts out_data this cycle
//   out_data   : received word, MSB = first data bit on the line
//   out_valid  : out_data and the error flags are valid
//   parity_err : held word failed even parity (qualified by out_valid)
//   frame_err  : held word's stop bit was 1 (qualified by out_valid)
//   overrun    : one-cycle pulse, a completed frame was dropped
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);

  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    input  out_ready,
    output out_data, out_valid, parity_err, frame_err, overrun
  );

  modport slave (
    output out_ready,
    input  out_data, out_valid, parity_err, frame_err, overrun
  );

endinterface : serial_frame_rx_if

// File: rtl/serial_frame_out_buf.sv
// ---------------------------------------------------------------------------
// serial_frame_out_buf
// One-entry valid/ready holding register for a received word and its error
// flags. A completion that finds the entry occupied and not being drained is
// dropped and reported with a one-cycle overrun pulse.
//   clk, reset : clock, asynchronous active-high reset
//   i_load     : a frame completes this cycle
//   i_data     : completed word
//   i_perr     : completed word's parity error
//   i_ferr     : completed word's framing error
//   i_ready    : consumer accepts the held word this cycle
//   o_data     : held word
//   o_valid    : held word is valid
//   o_perr     : held word's parity error
//   o_ferr     : held word's framing error
//   o_overrun  : one-cycle drop pulse
// ---------------------------------------------------------------------------
module serial_frame_out_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_perr,
  input  logic              i_ferr,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_perr,
  output logic              o_ferr,
  output logic              o_overrun
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_overrun;

  // The entry can take a new word when it is empty or being drained now.
  logic w_free;
  assign w_free = !r_valid || i_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        if (w_free) begin
          // Covers the simultaneous drain+load case: valid simply stays high.
          r_data  <= i_data;
          r_perr  <= i_perr;
          r_ferr  <= i_ferr;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_perr    = r_perr;
  assign o_ferr    = r_ferr;
  assign o_overrun = r_overrun;

endmodule : serial_frame_out_buf

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
// Receives framed words from a one-bit-per-clock serial line:
//   start bit (1), DATA_W data bits MSB-first, optional even-parity bit,
//   stop bit (0). The line idles low.
// Each completed frame (errored or not) is offered on a one-entry valid/ready
// output with parity/framing flags; a frame that finds the entry full is
// dropped and flagged with an overrun pulse.
//   clk    : rising-edge clock, Din sampled every edge
//   reset  : asynchronous active-high reset
//   Din    : serial bit stream
//   out_if : valid/ready output bundle (master side)
// Parameters: DATA_W (2..32), PARITY_EN (1 = parity bit present).
// ---------------------------------------------------------------------------
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Din,
  serial_frame_rx_if.master   out_if
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic              r_perr;

  // Completion happens on the edge that samples the stop bit; the buffer
  // registers the word on that same edge.
  logic w_complete;
  logic w_ferr;
  logic w_perr;
  assign w_complete = (r_state == STOP);
  assign w_ferr     = (Din != STOP_BIT);
  assign w_perr     = PARITY_EN ? r_perr : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= {DATA_W{IDLE_LEVEL}};
      r_perr  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register in this block sees
      // the pre-edge value of every other one regardless of statement order.
      case (r_state)
        IDLE: begin
          if (Din == START_BIT) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end
        end

        DATA: begin
          r_shreg <= {r_shreg[DATA_W-2:0], Din};
          // Counter holds at its terminal value instead of wrapping.
          if (r_cnt == CNT_LAST) begin
            if (PARITY_EN) r_state <= PARITY;
            else           r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          r_perr  <= ^{r_shreg, Din};
          r_state <= STOP;
        end

        STOP: begin
          // A high stop bit is a framing error, never a new start bit.
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  serial_frame_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_complete),
    .i_data    (r_shreg),
    .i_perr    (w_perr),
    .i_ferr    (w_ferr),
    .i_ready   (out_if.out_ready),
    .o_data    (out_if.out_data),
    .o_valid   (out_if.out_valid),
    .o_perr    (out_if.parity_err),
    .o_ferr    (out_if.frame_err),
    .o_overrun (out_if.overrun)
  );

endmodule : serial_frame_rx

// File: tb/tb_serial_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_rx
// Self-checking bench for serial_frame_rx (DATA_W=8, PARITY_EN=1).
// A reference model parses the driven bit stream frame by frame from a bit
// queue and tracks the expected output entry; every cycle the DUT outputs are
// compared against it, plus fixed expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_serial_frame_rx;
  import serial_frame_rx_pkg::*;

  localparam int DATA_W    = 8;
  localparam int PARITY_EN = 1;
  localparam int NBITS     = DATA_W + PARITY_EN + 1;  // bits after the start bit

  logic clk = 1'b0;
  logic reset;
  logic Din;

  serial_frame_rx_if #(.DATA_W(DATA_W)) rx_if ();

  serial_frame_rx #(
    .DATA_W    (DATA_W),
    .PARITY_EN (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Din    (Din),
    .out_if (rx_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random

  // Reference model state
  bit                collecting;
  bit                bitq[$];
  bit                exp_valid;
  bit                exp_perr;
  bit                exp_ferr;
  bit                exp_ovr;
  logic [DATA_W-1:0] exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    collecting = 1'b0;
    bitq.delete();
    exp_valid = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
    exp_data  = '0;
  endtask

  // Advance the model by one sampled line bit and one sampled ready.
  task automatic model_edge(input bit din, input bit rdy);
    bit                done;
    int                ones;
    logic [DATA_W-1:0] word;
    done = 1'b0;
    word = '0;
    ones = 0;
    if (!collecting) begin
      if (din == START_BIT) begin
        collecting = 1'b1;
        bitq.delete();
      end
    end else begin
      bitq.push_back(din);
      if (bitq.size() == NBITS) begin
        done       = 1'b1;
        collecting = 1'b0;
      end
    end

    exp_ovr = 1'b0;
    if (done) begin
      for (int i = 0; i < DATA_W; i++) begin
        word = word * 2 + DATA_W'(bitq[i]);
        ones += int'(bitq[i]);
      end
      if (!exp_valid || rdy) begin
        exp_valid = 1'b1;
        exp_data  = word;
        exp_perr  = (PARITY_EN != 0) ? (((ones + int'(bitq[DATA_W])) % 2) != 0) : 1'b0;
        exp_ferr  = bitq[NBITS-1];
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic compare();
    check("out_valid", rx_if.out_valid, exp_valid);
    check("overrun",   rx_if.overrun,   exp_ovr);
    if (exp_valid) begin
      check("out_data",   rx_if.out_data,   exp_data);
      check("parity_err", rx_if.parity_err, exp_perr);
      check("frame_err",  rx_if.frame_err,  exp_ferr);
    end
  endtask

  // One clock: drive at the falling edge, model on the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit din);
    bit rdy;
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    Din             = din;
    rx_if.out_ready = rdy;
    @(posedge clk);
    model_edge(din, rdy);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(IDLE_LEVEL);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input bit par_flip, input bit stop_bit);
    step(START_BIT);
    for (int i = DATA_W - 1; i >= 0; i--) step(d[i]);
    if (PARITY_EN != 0) step((^d) ^ par_flip);
    step(stop_bit);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_valid"}, rx_if.out_valid,  1'b0);
    check({tag, "_data"},  rx_if.out_data,   8'h00);
    check({tag, "_perr"},  rx_if.parity_err, 1'b0);
    check({tag, "_ferr"},  rx_if.frame_err,  1'b0);
    check({tag, "_ovr"},   rx_if.overrun,    1'b0);
    check({tag, "_state"}, dut.r_state,      IDLE);
    check({tag, "_cnt"},   dut.r_cnt,        3'd0);
    check({tag, "_shreg"}, dut.r_shreg,      8'h00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    Din   = IDLE_LEVEL;
  endtask

  initial begin
    reset           = 1'b1;
    Din             = IDLE_LEVEL;
    rx_if.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", rx_if.out_valid,  1'b0);
    check("rst_data",  rx_if.out_data,   8'h00);
    check("rst_perr",  rx_if.parity_err, 1'b0);
    check("rst_ferr",  rx_if.frame_err,  1'b0);
    check("rst_ovr",   rx_if.overrun,    1'b0);
    check("rst_state", dut.r_state,      IDLE);
    reset = 1'b0;
    idle(2);

    // 1: clean 0xA5, valid for exactly one cycle with ready high
    rdy_mode = 1;
    send_frame(8'hA5, 1'b0, 1'b0);
    check("t1_valid", rx_if.out_valid,  1'b1);
    check("t1_data",  rx_if.out_data,   8'hA5);
    check("t1_perr",  rx_if.parity_err, 1'b0);
    check("t1_ferr",  rx_if.frame_err,  1'b0);
    step(IDLE_LEVEL);
    check("t1_drop",  rx_if.out_valid,  1'b0);

    // 2: wrong parity bit
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t2_data", rx_if.out_data,   8'hA5);
    check("t2_perr", rx_if.parity_err, 1'b1);
    check("t2_ferr", rx_if.frame_err,  1'b0);
    idle(1);

    // 3: high stop bit, then idle line -> no second frame
    send_frame(8'hA5, 1'b0, 1'b1);
    check("t3_ferr", rx_if.frame_err,  1'b1);
    check("t3_perr", rx_if.parity_err, 1'b0);
    idle(12);
    check("t3_quiet", rx_if.out_valid, 1'b0);

    // 4: back-to-back frames, no idle gap
    send_frame(8'h3C, 1'b0, 1'b0);
    check("t4_first", rx_if.out_data, 8'h3C);
    send_frame(8'hFF, 1'b0, 1'b0);
    check("t4_second", rx_if.out_data,  8'hFF);
    check("t4_valid",  rx_if.out_valid, 1'b1);
    idle(2);

    // 5: consumer stalled, second frame overruns
    rdy_mode = 0;
    send_frame(8'h12, 1'b0, 1'b0);
    check("t5_hold", rx_if.out_data, 8'h12);
    send_frame(8'h34, 1'b0, 1'b0);
    check("t5_ovr",      rx_if.overrun,   1'b1);
    check("t5_kept",     rx_if.out_data,  8'h12);
    check("t5_valid",    rx_if.out_valid, 1'b1);
    rdy_mode = 1;
    step(IDLE_LEVEL);
    check("t5_ovr_end",  rx_if.overrun,   1'b0);
    check("t5_accepted", rx_if.out_valid, 1'b0);

    // 6: reset after four data bits, then a clean frame
    step(START_BIT);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    do_reset("t6");
    send_frame(8'hA5, 1'b0, 1'b0);
    check("t6_data", rx_if.out_data,   8'hA5);
    check("t6_perr", rx_if.parity_err, 1'b0);
    idle(2);

    // Random frames, random gaps, random ready, occasional bad parity/stop
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      send_frame(DATA_W'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      idle($urandom_range(0, 2));
    end
    rdy_mode = 1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_frame_rx
